// File: rtl/mor1kx_ctrl_wb_pipe_chain_if.sv
// Bus bundle for mor1kx_ctrl_wb_pipe_chain: execute-side capture, stage-0 ack,
// writeback outputs and the hazard/bypass query ports.
interface mor1kx_ctrl_wb_pipe_chain_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int EXC_WIDTH            = 11,
  parameter int NUM_READ_PORTS       = 2
);
  logic                                         padv_i;
  logic                                         in_valid_i;
  logic                                         in_rf_wb_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0]              in_rfd_adr_i;
  logic [OPTION_OPERAND_WIDTH-1:0]              in_result_i;
  logic [OPTION_OPERAND_WIDTH-1:0]              in_pc_i;
  logic [EXC_WIDTH-1:0]                         in_exc_i;
  logic                                         in_wait_i;
  logic                                         s0_ack_i;
  logic [OPTION_OPERAND_WIDTH-1:0]              s0_ack_data_i;
  logic                                         flush_i;
  logic [NUM_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0] rd_adr_i;

  logic                                         in_ready_o;
  logic                                         s0_valid_o;
  logic                                         s0_stall_o;
  logic [EXC_WIDTH-1:0]                         s0_exc_o;
  logic                                         exception_o;
  logic [OPTION_OPERAND_WIDTH-1:0]              s0_pc_o;
  logic                                         wb_valid_o;
  logic                                         wb_rf_wb_o;
  logic [OPTION_RF_ADDR_WIDTH-1:0]              wb_rfd_adr_o;
  logic [OPTION_OPERAND_WIDTH-1:0]              wb_result_o;
  logic [OPTION_OPERAND_WIDTH-1:0]              wb_pc_o;
  logic [NUM_READ_PORTS-1:0]                    hazard_o;
  logic [NUM_READ_PORTS-1:0]                    byp_valid_o;
  logic [NUM_READ_PORTS*OPTION_OPERAND_WIDTH-1:0] byp_data_o;

  modport master (
    output padv_i, in_valid_i, in_rf_wb_i, in_rfd_adr_i, in_result_i, in_pc_i,
           in_exc_i, in_wait_i, s0_ack_i, s0_ack_data_i, flush_i, rd_adr_i,
    input  in_ready_o, s0_valid_o, s0_stall_o, s0_exc_o, exception_o, s0_pc_o,
           wb_valid_o, wb_rf_wb_o, wb_rfd_adr_o, wb_result_o, wb_pc_o,
           hazard_o, byp_valid_o, byp_data_o
  );

  modport slave (
    input  padv_i, in_valid_i, in_rf_wb_i, in_rfd_adr_i, in_result_i, in_pc_i,
           in_exc_i, in_wait_i, s0_ack_i, s0_ack_data_i, flush_i, rd_adr_i,
    output in_ready_o, s0_valid_o, s0_stall_o, s0_exc_o, exception_o, s0_pc_o,
           wb_valid_o, wb_rf_wb_o, wb_rfd_adr_o, wb_result_o, wb_pc_o,
           hazard_o, byp_valid_o, byp_data_o
  );
endinterface

// File: rtl/mor1kx_ctrl_wb_pipe_chain.sv
// Control-to-writeback pipeline register chain with stallable stage 0 and hazard query.
// Optional operand bypass enabled by defining MOR1KX_CTRL_WB_BYPASS_EN.
module mor1kx_ctrl_wb_pipe_chain #(
  parameter int          OPTION_OPERAND_WIDTH = 32,
  parameter int          OPTION_RF_ADDR_WIDTH = 5,
  parameter logic [OPTION_OPERAND_WIDTH-1:0] OPTION_RESET_PC = '0,
  parameter int          DEPTH                = 2,   // legal 2..4, stage DEPTH-1 is writeback
  parameter int          EXC_WIDTH            = 11,
  parameter int          NUM_READ_PORTS       = 2
) (
  input  logic clk,
  input  logic rst,
  mor1kx_ctrl_wb_pipe_chain_if.slave bus
);
  localparam int OW = OPTION_OPERAND_WIDTH;
  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int NP = NUM_READ_PORTS;

  // Handshake: an instruction enters stage 0 on a cycle where padv_i and
  // in_ready_o are both high; in_ready_o drops only while a waiting op is unacked.
  logic                 s0_valid, s0_wait, s0_rf_wb;
  logic [AW-1:0]        s0_adr;
  logic [OW-1:0]        s0_result, s0_pc;
  logic [EXC_WIDTH-1:0] s0_exc, s0_exc_g;
  logic                 s0_stall, capture, s0_adv, exception;

  logic [DEPTH-1:1]     t_valid, t_rf_wb;
  logic [AW-1:0]        t_adr    [1:DEPTH-1];
  logic [OW-1:0]        t_result [1:DEPTH-1];
  logic [OW-1:0]        t_pc     [1:DEPTH-1];

  assign s0_stall  = s0_valid & s0_wait & ~bus.s0_ack_i;
  assign capture   = bus.padv_i & ~s0_stall;
  assign s0_adv    = s0_valid & ~s0_stall;
  assign s0_exc_g  = s0_exc & {EXC_WIDTH{s0_valid}};
  assign exception = |s0_exc_g;

  // Stage 0: a capture beats a same-cycle flush so the new instruction survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid  <= 1'b0;
      s0_wait   <= 1'b0;
      s0_rf_wb  <= 1'b0;
      s0_adr    <= '0;
      s0_result <= '0;
      s0_exc    <= '0;
      s0_pc     <= OPTION_RESET_PC;
    end else if (capture) begin
      s0_valid  <= bus.in_valid_i;
      s0_wait   <= bus.in_wait_i;
      s0_rf_wb  <= bus.in_rf_wb_i;
      s0_adr    <= bus.in_rfd_adr_i;
      s0_result <= bus.in_result_i;
      s0_exc    <= bus.in_exc_i;
      if (bus.in_valid_i)
        s0_pc <= bus.in_pc_i;
    end else if (s0_adv || bus.flush_i) begin
      s0_valid <= 1'b0;
      s0_rf_wb <= 1'b0;
    end
  end

  // Tail stages shift unconditionally; payload only moves with a live instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid <= '0;
      t_rf_wb <= '0;
      for (int k = 1; k < DEPTH; k++) begin
        t_adr[k]    <= '0;
        t_result[k] <= '0;
        t_pc[k]     <= OPTION_RESET_PC;
      end
    end else begin
      t_valid[1] <= s0_adv & ~bus.flush_i;
      t_rf_wb[1] <= s0_adv & s0_rf_wb & ~exception & ~bus.flush_i;
      if (s0_adv && !bus.flush_i) begin
        t_adr[1]    <= s0_adr;
        t_result[1] <= s0_wait ? bus.s0_ack_data_i : s0_result;
        t_pc[1]     <= s0_pc;
      end
      for (int k = 2; k < DEPTH; k++) begin
        t_valid[k] <= t_valid[k-1] & ~bus.flush_i;
        t_rf_wb[k] <= t_rf_wb[k-1] & ~bus.flush_i;
        if (t_valid[k-1] && !bus.flush_i) begin
          t_adr[k]    <= t_adr[k-1];
          t_result[k] <= t_result[k-1];
          t_pc[k]     <= t_pc[k-1];
        end
      end
    end
  end

  logic [AW-1:0]    q;
  logic [NP-1:0]    hazard, byp_valid;
  logic [NP*OW-1:0] byp_data;

`ifdef MOR1KX_CTRL_WB_BYPASS_EN
  logic          hit, pend;
  logic [OW-1:0] data;

  // Scan oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    q         = '0;
    hit       = 1'b0;
    pend      = 1'b0;
    data      = '0;
    hazard    = '0;
    byp_valid = '0;
    byp_data  = '0;
    for (int p = 0; p < NP; p++) begin
      q    = bus.rd_adr_i[p*AW +: AW];
      hit  = 1'b0;
      pend = 1'b0;
      data = '0;
      if (q != '0) begin
        for (int k = DEPTH-1; k >= 1; k--) begin
          if (t_valid[k] && t_rf_wb[k] && t_adr[k] == q) begin
            hit  = 1'b1;
            data = t_result[k];
          end
        end
        if (s0_valid && s0_rf_wb && s0_adr == q) begin
          hit  = 1'b1;
          pend = s0_wait & ~bus.s0_ack_i;
          data = s0_wait ? bus.s0_ack_data_i : s0_result;
        end
      end
      hazard[p]             = hit & pend;
      byp_valid[p]          = hit & ~pend;
      byp_data[p*OW +: OW]  = (hit && !pend) ? data : '0;
    end
  end
`else
  always_comb begin
    q         = '0;
    hazard    = '0;
    byp_valid = '0;
    byp_data  = '0;
    for (int p = 0; p < NP; p++) begin
      q = bus.rd_adr_i[p*AW +: AW];
      if (q != '0) begin
        if (s0_valid && s0_rf_wb && s0_adr == q)
          hazard[p] = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
          if (t_valid[k] && t_rf_wb[k] && t_adr[k] == q)
            hazard[p] = 1'b1;
        end
      end
    end
  end
`endif

  assign bus.in_ready_o   = ~s0_stall;
  assign bus.s0_valid_o   = s0_valid;
  assign bus.s0_stall_o   = s0_stall;
  assign bus.s0_exc_o     = s0_exc_g;
  assign bus.exception_o  = exception;
  assign bus.s0_pc_o      = s0_pc;
  assign bus.wb_valid_o   = t_valid[DEPTH-1];
  assign bus.wb_rf_wb_o   = t_rf_wb[DEPTH-1];
  assign bus.wb_rfd_adr_o = t_adr[DEPTH-1];
  assign bus.wb_result_o  = t_result[DEPTH-1];
  assign bus.wb_pc_o      = t_pc[DEPTH-1];
  assign bus.hazard_o     = hazard;
  assign bus.byp_valid_o  = byp_valid;
  assign bus.byp_data_o   = byp_data;
endmodule

// File: tb/tb_mor1kx_ctrl_wb_pipe_chain.sv
// Bench for mor1kx_ctrl_wb_pipe_chain: directed scenarios plus random traffic
// checked every cycle against an in-flight-instruction reference model.
module tb_mor1kx_ctrl_wb_pipe_chain;
  localparam int OW = 32, AW = 5, EW = 11, NP = 2, DEPTH = 3;
  localparam logic [OW-1:0] RESET_PC = 32'h0000_0100;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mor1kx_ctrl_wb_pipe_chain_if #(
    .OPTION_OPERAND_WIDTH(OW), .OPTION_RF_ADDR_WIDTH(AW),
    .EXC_WIDTH(EW), .NUM_READ_PORTS(NP)
  ) bus ();

  mor1kx_ctrl_wb_pipe_chain #(
    .OPTION_OPERAND_WIDTH(OW), .OPTION_RF_ADDR_WIDTH(AW), .OPTION_RESET_PC(RESET_PC),
    .DEPTH(DEPTH), .EXC_WIDTH(EW), .NUM_READ_PORTS(NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: instruction in stage 0 plus queue of in-flight slots behind it
  typedef struct packed {
    logic          valid;
    logic          rf_wb;
    logic          wt;
    logic [EW-1:0] exc;
    logic [AW-1:0] adr;
    logic [OW-1:0] result;
    logic [OW-1:0] pc;
  } op_t;

  op_t           m_s0;
  logic [OW-1:0] m_s0_pc, m_wb_pc;
  op_t           exp_q[$];   // index 0 = stage 1, index DEPTH-2 = writeback

  task automatic model_reset();
    m_s0    = '0;
    m_s0_pc = RESET_PC;
    m_wb_pc = RESET_PC;
    exp_q.delete();
    repeat (DEPTH-1) exp_q.push_back('0);
  endtask

  task automatic model_update();
    logic stall;
    op_t  nxt;
    if (rst) begin
      model_reset();
      return;
    end
    stall = m_s0.valid && m_s0.wt && !bus.s0_ack_i;
    nxt   = '0;
    if (m_s0.valid && !stall && !bus.flush_i) begin
      nxt.valid  = 1'b1;
      nxt.rf_wb  = m_s0.rf_wb && (m_s0.exc == '0);
      nxt.adr    = m_s0.adr;
      nxt.result = m_s0.wt ? bus.s0_ack_data_i : m_s0.result;
      nxt.pc     = m_s0.pc;
    end
    if (bus.flush_i)
      foreach (exp_q[i]) exp_q[i] = '0;
    exp_q.push_front(nxt);
    void'(exp_q.pop_back());
    if (exp_q[DEPTH-2].valid)
      m_wb_pc = exp_q[DEPTH-2].pc;
    if (bus.padv_i && !stall) begin
      m_s0.valid  = bus.in_valid_i;
      m_s0.rf_wb  = bus.in_rf_wb_i;
      m_s0.wt     = bus.in_wait_i;
      m_s0.exc    = bus.in_exc_i;
      m_s0.adr    = bus.in_rfd_adr_i;
      m_s0.result = bus.in_result_i;
      m_s0.pc     = bus.in_pc_i;
      if (bus.in_valid_i) m_s0_pc = bus.in_pc_i;
    end else if (bus.flush_i || (m_s0.valid && !stall)) begin
      m_s0 = '0;
    end
  endtask

  task automatic check_model();
    logic             stall, found, pend;
    logic [AW-1:0]    q;
    logic [OW-1:0]    data;
    logic [NP-1:0]    e_haz, e_bv;
    logic [NP*OW-1:0] e_bd;
    op_t              wb;
    stall = m_s0.valid && m_s0.wt && !bus.s0_ack_i;
    wb    = exp_q[DEPTH-2];
    check("in_ready", bus.in_ready_o, !stall);
    check("s0_stall", bus.s0_stall_o, stall);
    check("s0_valid", bus.s0_valid_o, m_s0.valid);
    check("s0_exc", bus.s0_exc_o, m_s0.valid ? m_s0.exc : '0);
    check("exception", bus.exception_o, m_s0.valid && (m_s0.exc != '0));
    check("s0_pc", bus.s0_pc_o, m_s0_pc);
    check("wb_valid", bus.wb_valid_o, wb.valid);
    check("wb_rf_wb", bus.wb_rf_wb_o, wb.rf_wb);
    check("wb_pc", bus.wb_pc_o, m_wb_pc);
    if (wb.valid) begin
      check("wb_adr", bus.wb_rfd_adr_o, wb.adr);
      check("wb_result", bus.wb_result_o, wb.result);
    end
    e_haz = '0; e_bv = '0; e_bd = '0;
    for (int p = 0; p < NP; p++) begin
      q = bus.rd_adr_i[p*AW +: AW];
      found = 1'b0; pend = 1'b0; data = '0;
      if (q != '0) begin
        if (m_s0.valid && m_s0.rf_wb && m_s0.adr == q) begin
          found = 1'b1;
          pend  = m_s0.wt && !bus.s0_ack_i;
          data  = m_s0.wt ? bus.s0_ack_data_i : m_s0.result;
        end
        for (int i = 0; i < DEPTH-1; i++) begin
          if (!found && exp_q[i].valid && exp_q[i].rf_wb && exp_q[i].adr == q) begin
            found = 1'b1;
            data  = exp_q[i].result;
          end
        end
      end
`ifdef MOR1KX_CTRL_WB_BYPASS_EN
      e_haz[p] = found && pend;
      e_bv[p]  = found && !pend;
      if (found && !pend) e_bd[p*OW +: OW] = data;
`else
      e_haz[p] = found;
`endif
    end
    check("hazard", bus.hazard_o, e_haz);
    check("byp_valid", bus.byp_valid_o, e_bv);
    check("byp_data", bus.byp_data_o, e_bd);
  endtask

  // driver tasks
  task automatic idle();
    bus.padv_i = 0; bus.in_valid_i = 0; bus.in_rf_wb_i = 0; bus.in_rfd_adr_i = '0;
    bus.in_result_i = '0; bus.in_pc_i = '0; bus.in_exc_i = '0; bus.in_wait_i = 0;
    bus.s0_ack_i = 0; bus.s0_ack_data_i = '0; bus.flush_i = 0; bus.rd_adr_i = '0;
  endtask

  task automatic set_op(input logic [AW-1:0] adr, input logic [OW-1:0] res,
                        input logic [OW-1:0] pc, input logic rf_wb, input logic wt,
                        input logic [EW-1:0] exc);
    bus.padv_i = 1; bus.in_valid_i = 1; bus.in_rf_wb_i = rf_wb; bus.in_rfd_adr_i = adr;
    bus.in_result_i = res; bus.in_pc_i = pc; bus.in_wait_i = wt; bus.in_exc_i = exc;
  endtask

  // one cycle: inputs already driven after the falling edge
  task automatic tick();
    #1;
    check_model();
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH+1) tick();
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", bus.in_ready_o, 1'b1);
    check("rst_s0_pc", bus.s0_pc_o, RESET_PC);
    check("rst_wb_pc", bus.wb_pc_o, RESET_PC);
    tick();
    rst = 0;
    tick();

    // plain ALU result reaches writeback three cycles after capture
    set_op(5'd5, 32'h1234, 32'h2000, 1, 0, '0);
    tick();
    idle();
    tick();
    #1 check("t1_wb_early", bus.wb_valid_o, 1'b0);
    tick();
    #1;
    check("t1_wb_valid", bus.wb_valid_o, 1'b1);
    check("t1_wb_rf_wb", bus.wb_rf_wb_o, 1'b1);
    check("t1_wb_adr", bus.wb_rfd_adr_o, 5'd5);
    check("t1_wb_result", bus.wb_result_o, 32'h1234);
    check("t1_wb_pc", bus.wb_pc_o, 32'h2000);
    drain();

    // load waits four cycles, then ack data replaces the result
    set_op(5'd3, 32'h0, 32'h3000, 1, 1, '0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1 check("t2_stalled", bus.in_ready_o, 1'b0);
      tick();
    end
    bus.s0_ack_i = 1; bus.s0_ack_data_i = 32'hCAFE;
    #1 check("t2_ack_ready", bus.in_ready_o, 1'b1);
    tick();
    idle();
    tick();
    #1;
    check("t2_wb_adr", bus.wb_rfd_adr_o, 5'd3);
    check("t2_wb_result", bus.wb_result_o, 32'hCAFE);
    drain();

    // flush with a same-cycle capture: tail cleared, new op survives
    set_op(5'd1, 32'h11, 32'h4000, 1, 0, '0); tick();
    set_op(5'd2, 32'h22, 32'h4004, 1, 0, '0); tick();
    set_op(5'd3, 32'h33, 32'h4008, 1, 0, '0); tick();
    set_op(5'd4, 32'h44, 32'h400C, 1, 0, '0);
    bus.flush_i = 1;
    tick();
    idle();
    #1;
    check("t3_s0_valid", bus.s0_valid_o, 1'b1);
    check("t3_wb_cleared", bus.wb_valid_o, 1'b0);
    tick(); tick();
    #1;
    check("t3_wb_valid", bus.wb_valid_o, 1'b1);
    check("t3_wb_result", bus.wb_result_o, 32'h44);
    drain();

    // exception suppresses the register write at writeback
    set_op(5'd6, 32'h66, 32'h5000, 1, 0, 11'h004);
    tick();
    idle();
    #1;
    check("t4_exception", bus.exception_o, 1'b1);
    check("t4_s0_exc", bus.s0_exc_o, 11'h004);
    tick(); tick();
    #1;
    check("t4_wb_valid", bus.wb_valid_o, 1'b1);
    check("t4_wb_rf_wb", bus.wb_rf_wb_o, 1'b0);
    drain();

    // r7 in stage 0 and writeback: youngest wins, r0 never hits
    set_op(5'd7, 32'hB, 32'h6000, 1, 0, '0); tick();
    set_op(5'd1, 32'h1, 32'h6004, 1, 0, '0); tick();
    set_op(5'd7, 32'hA, 32'h6008, 1, 0, '0); tick();
    idle();
    bus.rd_adr_i = {5'd0, 5'd7};
    #1;
`ifdef MOR1KX_CTRL_WB_BYPASS_EN
    check("t5_byp_valid", bus.byp_valid_o[0], 1'b1);
    check("t5_byp_data", bus.byp_data_o[OW-1:0], 32'hA);
    check("t5_hazard", bus.hazard_o[0], 1'b0);
`else
    check("t5_hazard", bus.hazard_o[0], 1'b1);
    check("t5_byp_valid", bus.byp_valid_o[0], 1'b0);
`endif
    check("t5_r0_hazard", bus.hazard_o[1], 1'b0);
    check("t5_r0_byp", bus.byp_valid_o[1], 1'b0);
    tick();
    drain();

    // reset while a load waits; a later ack must not resurrect it
    set_op(5'd3, 32'h77, 32'h7000, 1, 1, '0);
    tick();
    idle();
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    check("t6_s0_valid", bus.s0_valid_o, 1'b0);
    check("t6_s0_pc", bus.s0_pc_o, RESET_PC);
    check("t6_ready", bus.in_ready_o, 1'b1);
    bus.s0_ack_i = 1; bus.s0_ack_data_i = 32'hDEAD;
    tick();
    idle();
    tick(); tick();
    #1 check("t6_wb_valid", bus.wb_valid_o, 1'b0);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst                = ($urandom_range(0, 199) == 0);
      bus.padv_i         = ($urandom_range(0, 3) != 0);
      bus.in_valid_i     = ($urandom_range(0, 4) != 0);
      bus.in_rf_wb_i     = ($urandom_range(0, 3) != 0);
      bus.in_rfd_adr_i   = AW'($urandom_range(0, 7));
      bus.in_result_i    = $urandom;
      bus.in_pc_i        = $urandom;
      bus.in_exc_i       = ($urandom_range(0, 9) == 0) ? (EW'(1) << $urandom_range(0, EW-1)) : '0;
      bus.in_wait_i      = ($urandom_range(0, 2) == 0);
      bus.s0_ack_i       = ($urandom_range(0, 2) == 0);
      bus.s0_ack_data_i  = $urandom;
      bus.flush_i        = ($urandom_range(0, 29) == 0);
      bus.rd_adr_i       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      tick();
    end
    rst = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
